hazard_scoreboard: RTL and testbench

//   Parametrised register scoreboard for the MIPS decode stage. Replaces the single-cycle load-use check

---
 rtl/hazard_scoreboard.sv | 142 ++++++++++++++
 tb/tb_hazard_scoreboard.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Decode-stage register scoreboard: tracks in-flight multi-cycle ALU results and
// outstanding in-order loads, and raises stall on RAW, WAW-vs-load and load-queue-full hazards.
module hazard_scoreboard #(
  parameter int NREGS     = 32,
  parameter int ADDR_W    = 5,
  parameter int ALU_LAT   = 1,
  parameter int MAX_LOADS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs_addr,
  input  logic              id_rs_re,
  input  logic [ADDR_W-1:0] id_rt_addr,
  input  logic              id_rt_re,
  input  logic [ADDR_W-1:0] id_wr_addr,
  input  logic              id_we,
  input  logic              id_is_load,
  input  logic              flush,
  input  logic              mem_resp_valid,
  output logic              stall,
  output logic [NREGS-1:0]  busy_vec,
  output logic [ADDR_W-1:0] lq_head_addr,
  output logic [3:0]        lq_count,
  output logic              resp_err
);

  localparam int PTR_W = (MAX_LOADS > 1) ? $clog2(MAX_LOADS) : 1;

  logic [ALU_LAT-1:0] alu_v_q, alu_v_d;
  logic [ADDR_W-1:0]  alu_a_q [ALU_LAT];
  logic [ADDR_W-1:0]  alu_a_d [ALU_LAT];
  logic [ADDR_W-1:0]  lq_a_q  [MAX_LOADS];
  logic [ADDR_W-1:0]  lq_a_d  [MAX_LOADS];
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               err_q, err_d;

  logic [NREGS-1:0]   busy_alu_s, busy_load_s;
  logic               stall_s, issue_s, alu_push_s, lq_push_s, lq_pop_s;
  logic               lq_full_s, lq_empty_s;
  logic [ADDR_W-1:0]  lq_wr_addr_s;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(MAX_LOADS - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Busy bits from registered ALU pipe and the live part of the load queue.
  always_comb begin
    logic [PTR_W-1:0] p;
    busy_alu_s  = '0;
    busy_load_s = '0;
    p           = head_q;
    for (int i = 0; i < ALU_LAT; i++) begin
      busy_alu_s[alu_a_q[i]] = busy_alu_s[alu_a_q[i]] | alu_v_q[i];
    end
    for (int k = 0; k < MAX_LOADS; k++) begin
      busy_load_s[lq_a_q[p]] = busy_load_s[lq_a_q[p]] | (4'(k) < cnt_q);
      p = next_ptr(p);
    end
    busy_alu_s[0]  = 1'b0;
    busy_load_s[0] = 1'b0;
  end

  // Hazard detection and issue qualification.
  always_comb begin
    lq_full_s  = (cnt_q == 4'(MAX_LOADS));
    lq_empty_s = (cnt_q == 4'd0);
    stall_s = id_valid & ( (id_rs_re & (busy_alu_s[id_rs_addr] | busy_load_s[id_rs_addr]))
                         | (id_rt_re & (busy_alu_s[id_rt_addr] | busy_load_s[id_rt_addr]))
                         | (id_we & busy_load_s[id_wr_addr])
                         | (id_is_load & lq_full_s) );
    issue_s = id_valid & ~stall_s;
    // A redirected (flushed) instruction is never recorded.
    alu_push_s   = issue_s & ~flush & ~id_is_load & id_we & (id_wr_addr != '0);
    lq_push_s    = issue_s & ~flush & id_is_load;
    lq_pop_s     = mem_resp_valid & ~lq_empty_s;
    lq_wr_addr_s = (id_we == 1'b1) ? id_wr_addr : '0;
  end

  // Next-state for ALU pipe, load queue and error flag.
  always_comb begin
    alu_v_d    = '0;
    alu_a_d    = alu_a_q;
    lq_a_d     = lq_a_q;
    alu_v_d[0] = alu_push_s;
    alu_a_d[0] = id_wr_addr;
    for (int i = 1; i < ALU_LAT; i++) begin
      alu_v_d[i] = alu_v_q[i-1] & ~flush;
      alu_a_d[i] = alu_a_q[i-1];
    end
    if (lq_push_s) begin
      lq_a_d[tail_q] = lq_wr_addr_s;
    end else begin
      lq_a_d[tail_q] = lq_a_q[tail_q];
    end
    tail_d = lq_push_s ? next_ptr(tail_q) : tail_q;
    head_d = lq_pop_s  ? next_ptr(head_q) : head_q;
    case ({lq_push_s, lq_pop_s})
      2'b10:   cnt_d = cnt_q + 4'd1;
      2'b01:   cnt_d = cnt_q - 4'd1;
      default: cnt_d = cnt_q;
    endcase
    err_d = err_q | (mem_resp_valid & lq_empty_s);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      alu_v_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
      for (int i = 0; i < ALU_LAT; i++) begin
        alu_a_q[i] <= '0;
      end
      for (int i = 0; i < MAX_LOADS; i++) begin
        lq_a_q[i] <= '0;
      end
    end else begin
      alu_v_q <= alu_v_d;
      alu_a_q <= alu_a_d;
      lq_a_q  <= lq_a_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign stall        = stall_s;
  assign busy_vec     = busy_alu_s | busy_load_s;
  assign lq_head_addr = lq_empty_s ? '0 : lq_a_q[head_q];
  assign lq_count     = cnt_q;
  assign resp_err     = err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard with ALU_LAT=2, MAX_LOADS=2.
module tb_hazard_scoreboard;

  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, id_rs_re, id_rt_re, id_we, id_is_load, flush, mem_resp_valid;
  logic [AW-1:0] id_rs_addr, id_rt_addr, id_wr_addr;
  logic          stall, resp_err;
  logic [NREGS-1:0] busy_vec;
  logic [AW-1:0] lq_head_addr;
  logic [3:0]    lq_count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.NREGS(NREGS), .ADDR_W(AW), .ALU_LAT(2), .MAX_LOADS(2)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs_addr(id_rs_addr), .id_rs_re(id_rs_re),
    .id_rt_addr(id_rt_addr), .id_rt_re(id_rt_re),
    .id_wr_addr(id_wr_addr), .id_we(id_we), .id_is_load(id_is_load),
    .flush(flush), .mem_resp_valid(mem_resp_valid),
    .stall(stall), .busy_vec(busy_vec), .lq_head_addr(lq_head_addr),
    .lq_count(lq_count), .resp_err(resp_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_rs_re = 1'b0; id_rt_re = 1'b0; id_we = 1'b0;
    id_is_load = 1'b0; flush = 1'b0; mem_resp_valid = 1'b0;
    id_rs_addr = '0; id_rt_addr = '0; id_wr_addr = '0;
  endtask

  task automatic instr(input logic [AW-1:0] rs, input logic rs_re, input logic [AW-1:0] rt,
                       input logic rt_re, input logic [AW-1:0] wr, input logic we, input logic ld);
    id_valid = 1'b1; id_rs_addr = rs; id_rs_re = rs_re; id_rt_addr = rt; id_rt_re = rt_re;
    id_wr_addr = wr; id_we = we; id_is_load = ld;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1);
    mem_resp_valid = 1'b1;
    tick();
    tick();
    total_cnt++; if (busy_vec !== 32'h0) $display("FAIL reset_busy got %h exp %h", busy_vec, 32'h0); else pass_cnt++;
    total_cnt++; if (lq_count !== 4'd0) $display("FAIL reset_count got %0d exp %0d", lq_count, 0); else pass_cnt++;
    total_cnt++; if (resp_err !== 1'b0) $display("FAIL reset_err got %b exp %b", resp_err, 1'b0); else pass_cnt++;
    idle();
    #1;
    total_cnt++; if (stall !== 1'b0) $display("FAIL reset_stall got %b exp %b", stall, 1'b0); else pass_cnt++;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_alu_raw();
    instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
    #1;
    total_cnt++; if (stall !== 1'b0) $display("FAIL alu_producer_stall got %b exp %b", stall, 1'b0); else pass_cnt++;
    tick();
    instr(5'd5, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    #1;
    total_cnt++; if (stall !== 1'b1) $display("FAIL alu_raw_stall1 got %b exp %b", stall, 1'b1); else pass_cnt++;
    total_cnt++; if (busy_vec !== 32'h20) $display("FAIL alu_busy_stage0 got %h exp %h", busy_vec, 32'h20); else pass_cnt++;
    tick();
    total_cnt++; if (stall !== 1'b1) $display("FAIL alu_raw_stall2 got %b exp %b", stall, 1'b1); else pass_cnt++;
    tick();
    total_cnt++; if (stall !== 1'b0) $display("FAIL alu_raw_release got %b exp %b", stall, 1'b0); else pass_cnt++;
    total_cnt++; if (busy_vec !== 32'h0) $display("FAIL alu_busy_cleared got %h exp %h", busy_vec, 32'h0); else pass_cnt++;
    tick();
    idle();
    #1;
    total_cnt++; if (busy_vec !== 32'h80) $display("FAIL alu_consumer_busy got %h exp %h", busy_vec, 32'h80); else pass_cnt++;
    tick();
    tick();
    // Write to $0 is never tracked; a read of $0 never stalls.
    instr(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    #1;
    total_cnt++; if (stall !== 1'b0) $display("FAIL r0_write_stall got %b exp %b", stall, 1'b0); else pass_cnt++;
    tick();
    instr(5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0);
    #1;
    total_cnt++; if (stall !== 1'b0) $display("FAIL r0_read_stall got %b exp %b", stall, 1'b0); else pass_cnt++;
    total_cnt++; if (busy_vec !== 32'h0) $display("FAIL r0_busy got %h exp %h", busy_vec, 32'h0); else pass_cnt++;
    idle();
    tick();
  endtask

  task automatic test_load_use();
    instr(5'd29, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
    tick();
    instr(5'd1, 1'b0, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      #1;
      total_cnt++; if (stall !== 1'b1) $display("FAIL lu_stall_c%0d got %b exp %b", c, stall, 1'b1); else pass_cnt++;
      total_cnt++; if (lq_head_addr !== 5'd8) $display("FAIL lu_head_c%0d got %0d exp %0d", c, lq_head_addr, 8); else pass_cnt++;
      tick();
    end
    mem_resp_valid = 1'b1;
    #1;
    total_cnt++; if (stall !== 1'b1) $display("FAIL lu_no_bypass got %b exp %b", stall, 1'b1); else pass_cnt++;
    tick();
    mem_resp_valid = 1'b0;
    #1;
    total_cnt++; if (stall !== 1'b0) $display("FAIL lu_release got %b exp %b", stall, 1'b0); else pass_cnt++;
    total_cnt++; if (lq_count !== 4'd0) $display("FAIL lu_count got %0d exp %0d", lq_count, 0); else pass_cnt++;
    total_cnt++; if (lq_head_addr !== 5'd0) $display("FAIL lu_head_empty got %0d exp %0d", lq_head_addr, 0); else pass_cnt++;
    tick();
    idle();
    tick();
    tick();
  endtask

  task automatic test_queue_full();
    instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b1);
    tick();
    instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1);
    tick();
    instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);
    #1;
    total_cnt++; if (lq_count !== 4'd2) $display("FAIL qf_count_full got %0d exp %0d", lq_count, 2); else pass_cnt++;
    total_cnt++; if (lq_head_addr !== 5'd1) $display("FAIL qf_head1 got %0d exp %0d", lq_head_addr, 1); else pass_cnt++;
    total_cnt++; if (busy_vec !== 32'h6) $display("FAIL qf_busy12 got %h exp %h", busy_vec, 32'h6); else pass_cnt++;
    total_cnt++; if (stall !== 1'b1) $display("FAIL qf_full_stall got %b exp %b", stall, 1'b1); else pass_cnt++;
    mem_resp_valid = 1'b1;
    #1;
    total_cnt++; if (stall !== 1'b1) $display("FAIL qf_full_pop_stall got %b exp %b", stall, 1'b1); else pass_cnt++;
    tick();
    // LW $3 issues together with the pop of $2: count holds, head wraps.
    #1;
    total_cnt++; if (stall !== 1'b0) $display("FAIL qf_issue_next got %b exp %b", stall, 1'b0); else pass_cnt++;
    total_cnt++; if (lq_head_addr !== 5'd2) $display("FAIL qf_head2 got %0d exp %0d", lq_head_addr, 2); else pass_cnt++;
    total_cnt++; if (lq_count !== 4'd1) $display("FAIL qf_count1 got %0d exp %0d", lq_count, 1); else pass_cnt++;
    tick();
    idle();
    #1;
    total_cnt++; if (lq_count !== 4'd1) $display("FAIL qf_pushpop_count got %0d exp %0d", lq_count, 1); else pass_cnt++;
    total_cnt++; if (lq_head_addr !== 5'd3) $display("FAIL qf_head3 got %0d exp %0d", lq_head_addr, 3); else pass_cnt++;
    total_cnt++; if (busy_vec !== 32'h8) $display("FAIL qf_busy3 got %h exp %h", busy_vec, 32'h8); else pass_cnt++;
    mem_resp_valid = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    #1;
    total_cnt++; if (lq_count !== 4'd0) $display("FAIL qf_drained got %0d exp %0d", lq_count, 0); else pass_cnt++;
    total_cnt++; if (busy_vec !== 32'h0) $display("FAIL qf_busy_drained got %h exp %h", busy_vec, 32'h0); else pass_cnt++;
    total_cnt++; if (resp_err !== 1'b0) $display("FAIL qf_err got %b exp %b", resp_err, 1'b0); else pass_cnt++;
  endtask

  task automatic test_waw_flush();
    instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
    tick();
    instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
    #1;
    total_cnt++; if (stall !== 1'b1) $display("FAIL waw_stall got %b exp %b", stall, 1'b1); else pass_cnt++;
    instr(5'd2, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    total_cnt++; if (stall !== 1'b0) $display("FAIL flush_issue_stall got %b exp %b", stall, 1'b0); else pass_cnt++;
    tick();
    idle();
    #1;
    total_cnt++; if (busy_vec !== 32'h10) $display("FAIL flush_busy_s0 got %h exp %h", busy_vec, 32'h10); else pass_cnt++;
    total_cnt++; if (lq_count !== 4'd1) $display("FAIL flush_lq_kept got %0d exp %0d", lq_count, 1); else pass_cnt++;
    total_cnt++; if (lq_head_addr !== 5'd4) $display("FAIL flush_lq_head got %0d exp %0d", lq_head_addr, 4); else pass_cnt++;
    tick();
    total_cnt++; if (busy_vec !== 32'h10) $display("FAIL flush_busy_s1 got %h exp %h", busy_vec, 32'h10); else pass_cnt++;
    // A recorded ADD $6 is wiped by a later flush while still in the pipe.
    instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
    tick();
    idle();
    flush = 1'b1;
    #1;
    total_cnt++; if (busy_vec !== 32'h50) $display("FAIL flush_pre got %h exp %h", busy_vec, 32'h50); else pass_cnt++;
    tick();
    flush = 1'b0;
    #1;
    total_cnt++; if (busy_vec !== 32'h10) $display("FAIL flush_clears got %h exp %h", busy_vec, 32'h10); else pass_cnt++;
    mem_resp_valid = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    #1;
    total_cnt++; if (busy_vec !== 32'h0) $display("FAIL waw_drain got %h exp %h", busy_vec, 32'h0); else pass_cnt++;
  endtask

  task automatic test_spurious_resp();
    idle();
    mem_resp_valid = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    #1;
    total_cnt++; if (resp_err !== 1'b1) $display("FAIL spur_err got %b exp %b", resp_err, 1'b1); else pass_cnt++;
    total_cnt++; if (lq_count !== 4'd0) $display("FAIL spur_count got %0d exp %0d", lq_count, 0); else pass_cnt++;
    tick();
    tick();
    total_cnt++; if (resp_err !== 1'b1) $display("FAIL spur_sticky got %b exp %b", resp_err, 1'b1); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
    tick();
    instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
    tick();
    idle();
    #1;
    total_cnt++; if (busy_vec !== 32'h600) $display("FAIL mid_busy_before got %h exp %h", busy_vec, 32'h600); else pass_cnt++;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    total_cnt++; if (busy_vec !== 32'h0) $display("FAIL mid_busy_after got %h exp %h", busy_vec, 32'h0); else pass_cnt++;
    total_cnt++; if (lq_count !== 4'd0) $display("FAIL mid_count got %0d exp %0d", lq_count, 0); else pass_cnt++;
    total_cnt++; if (resp_err !== 1'b0) $display("FAIL mid_err got %b exp %b", resp_err, 1'b0); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    test_reset();
    test_alu_raw();
    test_load_use();
    test_queue_full();
    test_waw_flush();
    test_spurious_resp();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
